// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer
// Description : Upstream feeder for the I2C master core. The host writes
//               {slave address, data} commands into a FIFO. Each command is
//               replayed into the core register port as three consecutive
//               writes: address (reg 1), data (reg 2), start (reg 3).
//               Commands are paced on CORE_BUSY, with a fixed idle gap after
//               each transfer. This lets the host queue a burst of writes
//               without polling.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   BUS_CLK       in   1          clock, all logic on posedge
//   BUS_RST       in   1          synchronous active-high reset
//   BUS_ADD       in   ABUSWIDTH  host register address
//   BUS_DATA_IN   in   8          host write data
//   BUS_WR        in   1          host write strobe (1 cycle)
//   BUS_RD        in   1          host read strobe (1 cycle)
//   BUS_DATA_OUT  out  8          host read data, registered
//   CORE_ADD      out  3          register address to the I2C core
//   CORE_DATA     out  8          write data to the I2C core
//   CORE_WR       out  1          write strobe to the I2C core
//   CORE_BUSY     in   1          I2C core busy
//   seq_busy      out  1          FIFO non-empty or sequencer active
//   seq_error     out  1          sticky overflow | busy-timeout
// Host registers
//   0 W: soft reset    R: version (1)
//   1 R/W: staged slave address
//   2 W: push {reg1, data}   R: last pushed data
//   3 R: FIFO fill count
//   4 R/W: bit0 ENABLE
//   5 R: {6'b0, overflow, timeout}   W: clear both flags
// ============================================================================
module i2c_cmd_sequencer #(
  parameter int ABUSWIDTH    = 32,
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 1023,
  parameter int GAP_CYCLES   = 64
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  output logic [7:0]           BUS_DATA_OUT,
  output logic [2:0]           CORE_ADD,
  output logic [7:0]           CORE_DATA,
  output logic                 CORE_WR,
  input  logic                 CORE_BUSY,
  output logic                 seq_busy,
  output logic                 seq_error
);

  localparam int c_DEPTH   = 2 ** DEPTH_LOG2;
  localparam int c_CNT_W   = DEPTH_LOG2 + 1;
  localparam int c_TMR_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [7:0]            c_VERSION  = 8'd1;
  localparam logic [c_CNT_W-1:0]    c_FULL_CNT = c_CNT_W'(c_DEPTH);
  localparam logic [c_TMR_W-1:0]    c_TMO_LAST = c_TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [c_TMR_W-1:0]    c_GAP_LAST = c_TMR_W'(GAP_CYCLES - 1);
  localparam logic [2:0]            c_REG_ADDR  = 3'd1;
  localparam logic [2:0]            c_REG_DATA  = 3'd2;
  localparam logic [2:0]            c_REG_START = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_ADDR   = 3'd1,
    S_WR_DATA   = 3'd2,
    S_WR_START  = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [c_TMR_W-1:0]      timer_q, timer_d;
  logic [15:0]             cmd_q, cmd_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]      count_q, count_d;
  logic [7:0]              slave_addr_q, slave_addr_d;
  logic [7:0]              last_data_q, last_data_d;
  logic                    enable_q, enable_d;
  logic                    ovf_q, ovf_d;
  logic                    tmo_q, tmo_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [15:0]             mem_q [c_DEPTH];

  // --------------------------------------------------------------------------
  // Host decode
  // --------------------------------------------------------------------------
  logic w_wr_reg0, w_wr_reg1, w_wr_reg2, w_wr_reg4, w_wr_reg5;
  logic w_rst;
  logic w_empty, w_full;
  logic w_pop, w_push_ok, w_push_drop;
  logic w_tmo_set;

  assign w_wr_reg0 = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
  assign w_wr_reg1 = BUS_WR && (BUS_ADD == ABUSWIDTH'(1));
  assign w_wr_reg2 = BUS_WR && (BUS_ADD == ABUSWIDTH'(2));
  assign w_wr_reg4 = BUS_WR && (BUS_ADD == ABUSWIDTH'(4));
  assign w_wr_reg5 = BUS_WR && (BUS_ADD == ABUSWIDTH'(5));

  // A write to register 0 behaves exactly like the external reset.
  assign w_rst = BUS_RST || w_wr_reg0;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_FULL_CNT);

  // The head is popped on the cycle IDLE decides to launch a command.
  assign w_pop = (state_q == S_IDLE) && enable_q && !w_empty && !CORE_BUSY;

  // A push into a full FIFO is still accepted when a pop frees a slot in
  // the same cycle; otherwise it is dropped and flagged.
  assign w_push_ok   = w_wr_reg2 && (!w_full || w_pop);
  assign w_push_drop = w_wr_reg2 && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and core-port outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    w_tmo_set = 1'b0;
    CORE_WR   = 1'b0;
    CORE_ADD  = 3'd0;
    CORE_DATA = 8'd0;

    unique case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          state_d = S_WR_ADDR;
        end
      end
      S_WR_ADDR: begin
        CORE_WR   = 1'b1;
        CORE_ADD  = c_REG_ADDR;
        CORE_DATA = cmd_q[15:8];
        state_d   = S_WR_DATA;
      end
      S_WR_DATA: begin
        CORE_WR   = 1'b1;
        CORE_ADD  = c_REG_DATA;
        CORE_DATA = cmd_q[7:0];
        state_d   = S_WR_START;
      end
      S_WR_START: begin
        CORE_WR   = 1'b1;
        CORE_ADD  = c_REG_START;
        CORE_DATA = 8'd1;
        state_d   = S_WAIT_BUSY;
        timer_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (CORE_BUSY) begin
          state_d = S_WAIT_DONE;
          timer_d = '0;
        end else if (timer_q == c_TMO_LAST) begin
          // Core never acknowledged the start: drop the command and
          // still honour the inter-command gap.
          w_tmo_set = 1'b1;
          state_d   = S_GAP;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + c_TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!CORE_BUSY) begin
          state_d = S_GAP;
          timer_d = '0;
        end
      end
      S_GAP: begin
        if (timer_q == c_GAP_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + c_TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: FIFO pointers, host registers, flags, read mux
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    cmd_d        = cmd_q;
    slave_addr_d = slave_addr_q;
    last_data_d  = last_data_q;
    enable_d     = enable_q;
    ovf_d        = ovf_q;
    tmo_d        = tmo_q;
    rdata_d      = rdata_q;

    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      cmd_d    = mem_q[rd_ptr_q];
    end
    unique case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (w_wr_reg1) slave_addr_d = BUS_DATA_IN;
    if (w_wr_reg2) last_data_d  = BUS_DATA_IN;
    if (w_wr_reg4) enable_d     = BUS_DATA_IN[0];

    // Clear first so an event in the same cycle as the clear is not lost.
    if (w_wr_reg5) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (w_push_drop) ovf_d = 1'b1;
    if (w_tmo_set)   tmo_d = 1'b1;

    if (BUS_RD) begin
      if (BUS_ADD == ABUSWIDTH'(0))      rdata_d = c_VERSION;
      else if (BUS_ADD == ABUSWIDTH'(1)) rdata_d = slave_addr_q;
      else if (BUS_ADD == ABUSWIDTH'(2)) rdata_d = last_data_q;
      else if (BUS_ADD == ABUSWIDTH'(3)) rdata_d = 8'(count_q);
      else if (BUS_ADD == ABUSWIDTH'(4)) rdata_d = {7'd0, enable_q};
      else if (BUS_ADD == ABUSWIDTH'(5)) rdata_d = {6'd0, ovf_q, tmo_q};
      else                               rdata_d = 8'd0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_q        <= '0;
      slave_addr_q <= '0;
      last_data_q  <= '0;
      enable_q     <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_q        <= cmd_d;
      slave_addr_q <= slave_addr_d;
      last_data_q  <= last_data_d;
      enable_q     <= enable_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      rdata_q      <= rdata_d;
    end
  end

  // FIFO storage needs no reset: only slots between the pointers are read.
  always_ff @(posedge BUS_CLK) begin
    if (w_push_ok && !w_rst) begin
      mem_q[wr_ptr_q] <= {slave_addr_q, BUS_DATA_IN};
    end
  end

  assign BUS_DATA_OUT = rdata_q;
  assign seq_busy     = (state_q != S_IDLE) || !w_empty;
  assign seq_error    = ovf_q || tmo_q;

endmodule
`default_nettype wire
